// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit -- iterative multiply/divide unit for the EX stage.
//
// Executes MULT/MULTU (and DIV/DIVU when EX_MULDIV_DIV_EN is defined) into
// private HI/LO registers and services MFHI/MFLO/MTHI/MTLO. A multiply or
// divide takes one radix-2 step per cycle. stall_o holds the ID/EX register
// and everything upstream of it until the result has been committed.
//
// Configuration macro:
//   EX_MULDIV_DIV_EN  defined   -> restoring divider built, DIV/DIVU executed
//                     undefined -> DIV/DIVU are no-ops, multiplier only
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   rtype_i     EX instruction is R-type (qualifies funct_i)
//   funct_i     funct field of the EX instruction
//   rs_val_i    dividend / multiplicand / MTHI-MTLO source
//   rt_val_i    divisor / multiplier
//   stall_o     freeze ID/EX and earlier pipeline registers
//   mf_valid_o  EX instruction is MFHI/MFLO (combinational)
//   mf_data_o   HI for MFHI, LO for MFLO, else 0 (combinational)
//   hi_o, lo_o  current HI/LO registers
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rtype_i,
  input  logic [5:0]      funct_i,
  input  logic [XLEN-1:0] rs_val_i,
  input  logic [XLEN-1:0] rt_val_i,
  output logic            stall_o,
  output logic            mf_valid_o,
  output logic [XLEN-1:0] mf_data_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int CW = $clog2(XLEN);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       count_reg;
  logic [2*XLEN-1:0]   p_reg;     // product, or {remainder, quotient}
  logic [XLEN-1:0]     opd_reg;   // multiplicand or divisor magnitude
  logic                neg_lo_reg; // negate product / quotient
  logic [XLEN-1:0]     hi_reg, lo_reg;

  // ---- decode ----
  logic is_mult, is_multu, is_div, is_divu, is_md, div_by_zero;
  logic is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;

  assign is_mult  = rtype_i && (funct_i == F_MULT);
  assign is_multu = rtype_i && (funct_i == F_MULTU);
  assign is_mfhi  = rtype_i && (funct_i == F_MFHI);
  assign is_mflo  = rtype_i && (funct_i == F_MFLO);
  assign is_mthi  = rtype_i && (funct_i == F_MTHI);
  assign is_mtlo  = rtype_i && (funct_i == F_MTLO);

`ifdef EX_MULDIV_DIV_EN
  localparam logic [5:0] F_DIV  = 6'b011010;
  localparam logic [5:0] F_DIVU = 6'b011011;
  assign is_div      = rtype_i && (funct_i == F_DIV);
  assign is_divu     = rtype_i && (funct_i == F_DIVU);
  assign div_by_zero = (is_div || is_divu) && (rt_val_i == '0);
`else
  assign is_div      = 1'b0;
  assign is_divu     = 1'b0;
  assign div_by_zero = 1'b0;
`endif

  assign is_md = is_mult || is_multu || is_div || is_divu;
  assign a_neg = (is_mult || is_div) && rs_val_i[XLEN-1];
  assign b_neg = (is_mult || is_div) && rt_val_i[XLEN-1];
  assign abs_a = a_neg ? -rs_val_i : rs_val_i;
  assign abs_b = b_neg ? -rt_val_i : rt_val_i;

  // ---- one multiply step: add multiplicand if LSB set, then shift right ----
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, p_reg[2*XLEN-1:XLEN]} + (p_reg[0] ? {1'b0, opd_reg} : '0);
  assign mul_next = {mul_sum, p_reg[XLEN-1:1]};

`ifdef EX_MULDIV_DIV_EN
  // ---- one restoring-divide step ----
  // The shifted remainder is below 2*divisor, so bit XLEN of the difference
  // is a clean "remainder < divisor" flag.
  logic              div_reg;
  logic              neg_hi_reg;
  logic [XLEN:0]     rem_shift, rem_diff;
  logic [2*XLEN-1:0] div_next;
  assign rem_shift = p_reg[2*XLEN-1:XLEN-1];
  assign rem_diff  = rem_shift - {1'b0, opd_reg};
  assign div_next  = rem_diff[XLEN]
                   ? {rem_shift[XLEN-1:0], p_reg[XLEN-2:0], 1'b0}
                   : {rem_diff[XLEN-1:0],  p_reg[XLEN-2:0], 1'b1};
`endif

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    stall_o    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (is_md && !div_by_zero) begin
          state_next = RUN;
          stall_o    = 1'b1;
        end else if (is_md) begin
          state_next = DONE;   // divide by zero: no iteration needed
        end
      end
      RUN: begin
        stall_o = 1'b1;
        if (count_reg == CW'(XLEN-1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---- datapath ----
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= '0;
      p_reg      <= '0;
      opd_reg    <= '0;
      neg_lo_reg <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
`ifdef EX_MULDIV_DIV_EN
      div_reg    <= 1'b0;
      neg_hi_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          count_reg <= '0;
          if (div_by_zero) begin
            // Committed through the multiply path with no negation.
            p_reg      <= {rs_val_i, {XLEN{1'b1}}};
            neg_lo_reg <= 1'b0;
`ifdef EX_MULDIV_DIV_EN
            div_reg    <= 1'b0;
          end else if (is_div || is_divu) begin
            p_reg      <= {{XLEN{1'b0}}, abs_a};
            opd_reg    <= abs_b;
            neg_lo_reg <= a_neg ^ b_neg;
            neg_hi_reg <= a_neg;
            div_reg    <= 1'b1;
`endif
          end else if (is_mult || is_multu) begin
            p_reg      <= {{XLEN{1'b0}}, abs_b};
            opd_reg    <= abs_a;
            neg_lo_reg <= a_neg ^ b_neg;
`ifdef EX_MULDIV_DIV_EN
            div_reg    <= 1'b0;
`endif
          end else if (is_mthi) begin
            hi_reg <= rs_val_i;
          end else if (is_mtlo) begin
            lo_reg <= rs_val_i;
          end
        end
        RUN: begin
          count_reg <= count_reg + 1'b1;
`ifdef EX_MULDIV_DIV_EN
          p_reg <= div_reg ? div_next : mul_next;
`else
          p_reg <= mul_next;
`endif
        end
        DONE: begin
`ifdef EX_MULDIV_DIV_EN
          if (div_reg) begin
            lo_reg <= neg_lo_reg ? -p_reg[XLEN-1:0] : p_reg[XLEN-1:0];
            hi_reg <= neg_hi_reg ? -p_reg[2*XLEN-1:XLEN] : p_reg[2*XLEN-1:XLEN];
          end else
`endif
          begin
            {hi_reg, lo_reg} <= neg_lo_reg ? -p_reg : p_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o       = hi_reg;
  assign lo_o       = lo_reg;
  assign mf_valid_o = is_mfhi || is_mflo;
  assign mf_data_o  = is_mfhi ? hi_reg : (is_mflo ? lo_reg : '0);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Testbench for ex_muldiv_unit. Stimulus pushes expected MFHI/MFLO data into
// a scoreboard queue; a negedge monitor pops and compares whenever the DUT
// flags mf_valid_o. Stall lengths and reset state are checked inline.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rtype;
  logic [5:0]  funct;
  logic [31:0] rs, rtv;
  logic        stall_o, mf_valid_o;
  logic [31:0] mf_data_o, hi_o, lo_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

`ifdef EX_MULDIV_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif
  localparam int DIV_STALL = DIV_ON ? 33 : 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rtype_i    (rtype),
    .funct_i    (funct),
    .rs_val_i   (rs),
    .rt_val_i   (rtv),
    .stall_o    (stall_o),
    .mf_valid_o (mf_valid_o),
    .mf_data_o  (mf_data_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  // Monitor: one pop per cycle in which the DUT presents MF data.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && mf_valid_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_mf: got %08h expected no output", mf_data_o);
      end else begin
        e = sb_q.pop_front();
        check(e.name, mf_data_o, e.exp);
      end
    end
  end

  task automatic drive(input logic r, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    rtype = r; funct = f; rs = a; rtv = b;
  endtask

  // Present a mul/div op and hold it while stall_o is high; count stall cycles.
  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stall);
    int n;
    n = 0;
    drive(1'b1, f, a, b);
    while (n < 100) begin
      @(negedge clk);
      if (!stall_o) break;
      n++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check({name, " stall_cycles"}, n, exp_stall);
  endtask

  task automatic mf(input string name, input bit sel_hi, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    drive(1'b1, sel_hi ? 6'h10 : 6'h12, 32'h0, 32'h0);
    @(negedge clk);
    check({name, " stall"}, {31'b0, stall_o}, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic mt(input string name, input bit sel_hi, input logic [31:0] val);
    drive(1'b1, sel_hi ? 6'h11 : 6'h13, val, 32'h0);
    @(negedge clk);
    check({name, " stall"}, {31'b0, stall_o}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] hi_e, lo_e, old_lo;
    rst = 1'b1;
    drive(1'b0, 6'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset hi_o", hi_o, 32'h0);
    check("reset lo_o", lo_o, 32'h0);
    check("reset stall_o", {31'b0, stall_o}, 32'h0);
    check("reset mf_valid_o", {31'b0, mf_valid_o}, 32'h0);
    check("reset mf_data_o", mf_data_o, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // MULTU max x max
    run_op("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    hi_e = 32'hFFFF_FFFE; lo_e = 32'h0000_0001;
    mf("multu_max lo", 1'b0, lo_e);
    mf("multu_max hi", 1'b1, hi_e);

    // MULT -3 x 7, MFLO back-to-back in cycle 34
    run_op("mult_m3_7", 6'h18, 32'hFFFF_FFFD, 32'd7, 33);
    hi_e = 32'hFFFF_FFFF; lo_e = 32'hFFFF_FFEB;
    mf("mult_m3_7 lo", 1'b0, lo_e);
    mf("mult_m3_7 hi", 1'b1, hi_e);

    // MULT min x min = 2^62
    run_op("mult_min_min", 6'h18, 32'h8000_0000, 32'h8000_0000, 33);
    hi_e = 32'h4000_0000; lo_e = 32'h0;
    mf("mult_min_min lo", 1'b0, lo_e);
    mf("mult_min_min hi", 1'b1, hi_e);

    // DIV -7 / 2
    run_op("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2, DIV_STALL);
    if (DIV_ON) begin hi_e = 32'hFFFF_FFFF; lo_e = 32'hFFFF_FFFD; end
    mf("div_m7_2 lo", 1'b0, lo_e);
    mf("div_m7_2 hi", 1'b1, hi_e);

    // DIVU 100 / 7
    run_op("divu_100_7", 6'h1B, 32'd100, 32'd7, DIV_STALL);
    if (DIV_ON) begin hi_e = 32'd2; lo_e = 32'd14; end
    mf("divu_100_7 lo", 1'b0, lo_e);
    mf("divu_100_7 hi", 1'b1, hi_e);

    // DIV overflow case: min / -1
    run_op("div_min_m1", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, DIV_STALL);
    if (DIV_ON) begin hi_e = 32'h0; lo_e = 32'h8000_0000; end
    mf("div_min_m1 lo", 1'b0, lo_e);
    mf("div_min_m1 hi", 1'b1, hi_e);

    // DIVU 5 / 0: no stall; cycle 1 sees old LO, new values from cycle 2
    old_lo = lo_e;
    run_op("divu_5_0", 6'h1B, 32'd5, 32'd0, 0);
    if (DIV_ON) begin hi_e = 32'd5; lo_e = 32'hFFFF_FFFF; end
    mf("divu_5_0 cycle1 old lo", 1'b0, old_lo);
    mf("divu_5_0 hi", 1'b1, hi_e);
    mf("divu_5_0 lo", 1'b0, lo_e);

    // MTHI / MTLO
    mt("mthi", 1'b1, 32'h1234_5678);
    hi_e = 32'h1234_5678;
    mf("mthi readback", 1'b1, hi_e);
    mt("mtlo", 1'b0, 32'hCAFE_F00D);
    lo_e = 32'hCAFE_F00D;
    mf("mtlo readback", 1'b0, lo_e);

    // Non-R-type with MULT funct, and an unknown R-type funct: no action
    drive(1'b0, 6'h18, 32'd3, 32'd4);
    @(negedge clk);
    check("nonrtype stall", {31'b0, stall_o}, 32'h0);
    check("nonrtype mf_data", mf_data_o, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 6'h20, 32'd3, 32'd4);
    @(negedge clk);
    check("unknown funct stall", {31'b0, stall_o}, 32'h0);
    @(posedge clk); #1;
    check("noop hi unchanged", hi_o, hi_e);
    check("noop lo unchanged", lo_o, lo_e);

    // Reset in RUN at count 10 (cycle 11 of the op)
    drive(1'b1, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (11) @(posedge clk);
    #1;
    check("pre-reset stall", {31'b0, stall_o}, 32'h1);
    rst = 1'b1;
    drive(1'b0, 6'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrun reset stall", {31'b0, stall_o}, 32'h0);
    check("midrun reset hi", hi_o, 32'h0);
    check("midrun reset lo", lo_o, 32'h0);
    @(posedge clk); #1;
    run_op("multu_3_4", 6'h19, 32'd3, 32'd4, 33);
    mf("multu_3_4 lo", 1'b0, 32'd12);
    mf("multu_3_4 hi", 1'b1, 32'd0);

    drive(1'b0, 6'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit for the EX stage. It takes the R-type instruction held in the ID/EX pipeline register and executes MULT, MULTU, DIV and DIVU into private HI/LO registers. It also services MFHI, MFLO, MTHI and MTLO. While a multi-cycle operation runs, it drives `stall_o`; the hazard logic ANDs this into the ID/EX (and upstream) `en_reg` so the instruction stays frozen in EX until the result is committed.

## Interface
- `XLEN`, default 32: operand/HI/LO width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `rtype_i`  in  1  instruction in EX is R-type (decoded from ID/EX EX-control); qualifies `funct_i`.
- `funct_i`  in  6  funct field from ID/EX.
- `rs_val_i`  in  32  RD1 from ID/EX (dividend / multiplicand / MTxx source).
- `rt_val_i`  in  32  RD2 from ID/EX (divisor / multiplier).
- `stall_o`  out  1  freeze the pipeline registers at and before ID/EX.
- `mf_valid_o`  out  1  combinational; the EX instruction is MFHI/MFLO.
- `mf_data_o`  out  32  combinational; HI for MFHI, LO for MFLO, else 0.
- `hi_o`, `lo_o`  out  32  current HI/LO registers.

## Operation
- Decode, valid only when `rtype_i`=1:
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
  - 010000 MFHI, 010010 MFLO, 010001 MTHI, 010011 MTLO.
  - Any other funct: no action.
- FSM states: IDLE, RUN, DONE.
- **IDLE + mul/div op:** latch operand magnitudes (absolute values for signed ops), result-sign flags, count=0, then go to RUN.
  - Exception, DIV/DIVU with `rt_val_i`=0: go directly to DONE with HI=`rs_val_i`, LO=32'hFFFF_FFFF.
- **RUN:** one radix-2 step per cycle.
  - Multiply: shift-add into a 64-bit product.
  - Divide: restoring division, producing quotient and remainder.
  - count increments; leave RUN for DONE when count==31.
- **DONE:** apply sign correction, then write HI/LO.
  - Multiply: {HI,LO} = product; for MULT, negated if the operand signs differ.
  - Divide: LO = quotient, HI = remainder.
  - DIV signs: quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
  - Return to IDLE. DONE never starts a new op, even though the same instruction is still in EX.
- **IDLE + MTHI/MTLO:** HI (or LO) = `rs_val_i` at the clock edge; no stall.
- **MFHI/MFLO:** `mf_data_o` reads the current HI/LO register, not bypassed.
- `stall_o` = (IDLE & mul/div op & not divide-by-zero) | RUN. It is 0 in DONE, so ID/EX loads the next instruction at the end of DONE.
- Arithmetic is modulo 2^32 per half. DIV of 0x8000_0000 / 0xFFFF_FFFF gives LO=0x8000_0000, HI=0.

## Timing
- Reset values: state IDLE, HI=0, LO=0, count=0, `stall_o`=0, `mf_valid_o`=0, `mf_data_o`=0.
- Mul/div op first seen in EX in cycle 0:
  - `stall_o` is high in cycles 0–32 (33 cycles).
  - RUN occupies cycles 1–32.
  - DONE is cycle 33.
  - HI/LO are visible from cycle 34.
- Divide-by-zero: `stall_o` is low throughout; DONE is cycle 1 and HI/LO are visible from cycle 2.
  - The instruction leaves EX at the end of cycle 0.
  - An MFHI/MFLO arriving in cycle 1 reads the old values; the hazard unit must insert one bubble.
- Back-to-back: an MFLO directly after MULT enters EX in cycle 34 and reads the new LO, with no extra stall.
- MTHI/MTLO: the write is visible in the next cycle.
- `rst` in any state: abort the op, clear HI/LO, `stall_o`=0 in the following cycle.
- Inputs are ignored in RUN and DONE; the frozen ID/EX keeps them stable.

## Configuration
- `EX_MULDIV_DIV_EN` defined: the divider datapath and DIV/DIVU are implemented as described.
- `EX_MULDIV_DIV_EN` undefined: DIV/DIVU decode as no-ops (no stall, HI/LO unchanged); only the multiplier is built.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → `stall_o` high exactly 33 cycles; then HI=0xFFFF_FFFE, LO=0x0000_0001.
- MULT −3 × 7, then MFLO next → LO=0xFFFF_FFEB, HI=0xFFFF_FFFF; `mf_data_o`=0xFFFF_FFEB in cycle 34.
- DIV −7 / 2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU 100 / 7 → LO=14, HI=2.
- DIVU 5 / 0 → no stall; cycle 2: HI=5, LO=0xFFFF_FFFF.
- MTHI 0x1234_5678, then MFHI → `mf_data_o`=0x1234_5678, `stall_o` never asserted.
- `rst` at RUN count 10 of a MULTU → next cycle `stall_o`=0, HI=LO=0, state IDLE; a fresh MULTU 3×4 gives LO=12.
